// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dscr7.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__dscr7
//
// Self-synchronizing serial descrambler for the polynomial x^7 + x^6 + 1.
// This is the receive side of the matching serial scrambler. The block keeps
// a history of the last seven scrambled bits. Each output bit is
//     q_n = d_n ^ d_(n-6) ^ d_(n-7)
// so the history fills with the line data itself, and the block locks on by
// itself after seven bits.
//
// Parameters
//   LOCK_CNT   accepted bits after reset/CLR before LOCK asserts (7..15)
//
// Ports
//   CLK        rising-edge clock
//   RN         asynchronous active-low reset
//   CLR        synchronous clear; has priority over VALID_IN, and the bit
//              presented with it is dropped
//   D          scrambled serial input bit
//   VALID_IN   D is valid this cycle (no back-pressure, full rate)
//   Q          descrambled bit, registered, one cycle after VALID_IN
//   VALID_OUT  Q valid, registered
//   LOCK       history holds at least LOCK_CNT real bits, registered
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__dscr7 #(
    parameter int LOCK_CNT = 7
) (
    input  logic CLK,
    input  logic RN,
    input  logic CLR,
    input  logic D,
    input  logic VALID_IN,
    output logic Q,
    output logic VALID_OUT,
    output logic LOCK
);

    // The counter is 4 bits wide, which limits LOCK_CNT to 15. The counter
    // saturates at LOCK_CNT, so it never wraps.
    localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);

    // Descrambler tap equation. hist[0] is the newest bit and hist[6] the
    // oldest, so taps 6 and 7 back are hist[5] and hist[6].
    function automatic logic descramble_bit(input logic d, input logic [6:0] hist);
        return d ^ hist[5] ^ hist[6];
    endfunction

    logic [6:0] s_r;
    logic [6:0] s_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       q_r;
    logic       q_nxt_s;
    logic       valid_out_r;
    logic       valid_out_nxt_s;
    logic       lock_r;
    logic       lock_nxt_s;

    // Next-state logic: clear, accept one bit, or hold.
    always_comb begin
        s_nxt_s         = s_r;
        cnt_nxt_s       = cnt_r;
        q_nxt_s         = q_r;
        valid_out_nxt_s = 1'b0;
        if (CLR) begin
            s_nxt_s   = 7'd0;
            cnt_nxt_s = 4'd0;
            q_nxt_s   = 1'b0;
        end else if (VALID_IN) begin
            // The history shifts in the scrambled bit D, not the output Q.
            s_nxt_s         = {s_r[5:0], D};
            q_nxt_s         = descramble_bit(D, s_r);
            valid_out_nxt_s = 1'b1;
            if (cnt_r < LOCK_CNT_C) begin
                cnt_nxt_s = cnt_r + 4'd1;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            s_nxt_s   = s_r;
            cnt_nxt_s = cnt_r;
            q_nxt_s   = q_r;
        end
        // LOCK follows the next counter value. It rises on the edge that
        // accepts bit LOCK_CNT, together with that bit's VALID_OUT. It holds
        // through idle cycles because the counter saturates and holds.
        lock_nxt_s = (cnt_nxt_s == LOCK_CNT_C);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            s_r         <= 7'd0;
            cnt_r       <= 4'd0;
            q_r         <= 1'b0;
            valid_out_r <= 1'b0;
            lock_r      <= 1'b0;
        end else begin
            s_r         <= s_nxt_s;
            cnt_r       <= cnt_nxt_s;
            q_r         <= q_nxt_s;
            valid_out_r <= valid_out_nxt_s;
            lock_r      <= lock_nxt_s;
        end
    end

    assign Q         = q_r;
    assign VALID_OUT = valid_out_r;
    assign LOCK      = lock_r;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__dscr7.md
GF180MCU_FD_SC_MCU9T5V0__DSCR7 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dscr7

Interface
REQ-001: Parameter LOCK_CNT, default 7, number of accepted input bits after reset or CLR before LOCK asserts; legal range 7..15.
REQ-002: CLK  input  1  rising-edge clock; the block has one clock.
REQ-003: RN  input  1  reset, asynchronous, active-low.
REQ-004: CLR  input  1  synchronous clear of the shift state, counter and outputs.
REQ-005: D  input  1  scrambled serial data bit.
REQ-006: VALID_IN  input  1  D is valid this cycle; one bit is accepted per cycle when high.
REQ-007: Q  output  1  descrambled serial data bit, registered.
REQ-008: VALID_OUT  output  1  Q is valid this cycle, registered.
REQ-009: LOCK  output  1  shift register holds LOCK_CNT or more real input bits, registered.

Function
REQ-010: The block shall be a self-synchronizing descrambler for polynomial x^7+x^6+1, the receive end of the matching serial scrambler.
REQ-011: The block shall hold a 7-bit history register S[6:0]; S[0] is the most recent accepted bit and S[6] the oldest.
REQ-012: On a CLK edge with VALID_IN=1 and CLR=0, S shall shift as S <= {S[5:0], D}; the shift input is the scrambled bit D, not Q.
REQ-013: On that same edge, Q shall load D XOR S[5] XOR S[6], using S values from before the edge (d_n ^ d_n-6 ^ d_n-7).
REQ-014: On that same edge, VALID_OUT shall load 1, giving latency exactly one cycle from VALID_IN to VALID_OUT.
REQ-015: On a CLK edge with VALID_IN=0 and CLR=0, S and Q shall hold, VALID_OUT shall load 0, and the counter shall hold.
REQ-016: A 4-bit accepted-bit counter shall increment on each accepted bit and saturate at LOCK_CNT; it shall not wrap.
REQ-017: LOCK shall be 1 whenever the registered counter equals LOCK_CNT.
- LOCK rises on the edge that accepts bit number LOCK_CNT.
- So LOCK and the VALID_OUT of that bit assert together.
REQ-018: Once high, LOCK shall stay high until CLR or reset; idle cycles shall not drop it.
REQ-019: Bits accepted before LOCK shall still be output with VALID_OUT=1; their Q values are computed with zero history and are not guaranteed correct.
REQ-020: On a CLK edge with CLR=1, the block shall clear S, the counter, Q, VALID_OUT and LOCK to 0.
- CLR has priority over VALID_IN.
- A bit presented with CLR=1 is discarded.
REQ-021: The first VALID_IN after CLR deasserts shall be treated exactly as the first bit after reset.
REQ-022: Back-to-back VALID_IN on consecutive cycles shall be supported at full rate, one bit per cycle, with no stall or bubble.
REQ-023: There shall be no back-pressure; the block always accepts a bit when VALID_IN=1.

Reset
REQ-024: While RN=0, S, the counter, Q, VALID_OUT and LOCK shall be 0, asynchronously, independent of CLK.
REQ-025: RN deasserting mid-stream shall restart the stream: history is zero, the counter is zero, and LOCK is low until LOCK_CNT new bits are accepted.
REQ-026: Reset shall dominate CLR and VALID_IN.

Verification
REQ-027: Reset with RN=0 while CLK toggles and VALID_IN=1 -> Q=0, VALID_OUT=0 and LOCK=0 throughout; the first bit after release appears one cycle later.
REQ-028: After reset, feed 20 zero bits back-to-back -> Q=0 on all 20 outputs; LOCK rises together with the 7th VALID_OUT.
REQ-029: After reset, feed 1 then 19 zeros -> Q=1 on output bits 1, 7 and 8, and 0 on all others (impulse response).
REQ-030: Feed a random 1000-bit payload through a reference x^7+x^6+1 scrambler with arbitrary seed 7'h5A -> after LOCK, Q matches the payload bit-for-bit at one-cycle latency.
REQ-031: Random VALID_IN gaps with 50% duty -> output is identical to the gapless run, VALID_OUT mirrors VALID_IN delayed by one cycle, and LOCK does not drop during gaps.
REQ-032: Assert CLR for one cycle after LOCK, with VALID_IN=1 on that cycle -> the next cycle shows LOCK=0 and VALID_OUT=0; the discarded bit never appears at Q; LOCK returns after LOCK_CNT further bits.
